// File: rtl/clkout_sched_pkg.sv
// clkout_sched_pkg: shared types and constants for the clkout_sched burst controller.
//   state_t      : FSM states (IDLE, HIGH, LOW)
//   DIV_MIN      : smallest effective half-period; a div of 0 is promoted to this
//   RST_*        : reset values of the registered outputs
package clkout_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   localparam int unsigned DIV_MIN      = 1;

   localparam logic        RST_CLKOUT   = 1'b0;
   localparam logic        RST_Q        = 1'b0;
   localparam logic        RST_BUSY     = 1'b0;
   localparam logic        RST_DONE     = 1'b0;
   localparam int unsigned RST_EDGE_CNT = 0;

endpackage

// File: rtl/clkout_sched_if.sv
// clkout_sched_if: request/status bundle between the burst sequencer (master)
// and the clkout_sched block (slave).
//   start, div, nburst, d, [abort]  : master -> slave
//   clkout, q, busy, done, edge_cnt : slave -> master
// Macro CLKOUT_SCHED_ABORT_EN adds the abort request signal.
interface clkout_sched_if #(
   parameter int unsigned DIV_W = 8,
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] nburst;
   logic             d;
`ifdef CLKOUT_SCHED_ABORT_EN
   logic             abort;
`endif
   logic             clkout;
   logic             q;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] edge_cnt;

`ifdef CLKOUT_SCHED_ABORT_EN
   modport master (output start, div, nburst, d, abort,
                   input  clkout, q, busy, done, edge_cnt);
   modport slave  (input  start, div, nburst, d, abort,
                   output clkout, q, busy, done, edge_cnt);
`else
   modport master (output start, div, nburst, d,
                   input  clkout, q, busy, done, edge_cnt);
   modport slave  (input  start, div, nburst, d,
                   output clkout, q, busy, done, edge_cnt);
`endif
endinterface

// File: rtl/clkout_sched_phase_cnt.sv
// clkout_sched_phase_cnt: loadable down-counter timing one HIGH or LOW phase.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length minus one
//   tc         : terminal count, high when the counter is at zero
module clkout_sched_phase_cnt #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   output logic             tc
);
   logic [DIV_W-1:0] r_cnt;

   // Count down to zero and park there until reloaded
   always_ff @(posedge clk) begin
      if (reset)               r_cnt <= '0;
      else if (load)           r_cnt <= load_val;
      else if (r_cnt != '0)    r_cnt <= r_cnt - DIV_W'(1);
   end

   assign tc = (r_cnt == '0);
endmodule

// File: rtl/clkout_sched.sv
// clkout_sched: emits a counted burst of derived-clock pulses of programmable
// half-period and captures d into q on every clkout rising edge.
//   clk, reset : clock, synchronous active-high reset
//   sif        : clkout_sched_if slave (start/div/nburst/d in; clkout/q/busy/done/edge_cnt out)
// Macro CLKOUT_SCHED_ABORT_EN enables the abort input that ends a burst early.
module clkout_sched
   import clkout_sched_pkg::*;
#(
   parameter int unsigned DIV_W = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   clkout_sched_if.slave  sif
);
   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_div, w_div_eff, w_load_val;
   logic [CNT_W-1:0] r_nburst, r_edge_cnt, w_edge_nxt;
   logic             r_clkout, r_q, r_busy, r_done;
   logic             w_clkout_nxt, w_q_nxt, w_busy_nxt, w_done_nxt;
   logic             w_load, w_latch, w_tc, w_abort;

`ifdef CLKOUT_SCHED_ABORT_EN
   assign w_abort = sif.abort;
`else
   assign w_abort = 1'b0;
`endif

   // A half-period of zero behaves as the minimum
   assign w_div_eff = (sif.div == '0) ? DIV_W'(DIV_MIN) : sif.div;

   clkout_sched_phase_cnt #(.DIV_W(DIV_W)) u_phase_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (w_load),
      .load_val (w_load_val),
      .tc       (w_tc)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and next output values
   always_comb begin
      w_state_nxt  = r_state;
      w_clkout_nxt = r_clkout;
      w_q_nxt      = r_q;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_edge_nxt   = r_edge_cnt;
      w_load       = 1'b0;
      w_load_val   = r_div - DIV_W'(1);
      w_latch      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (sif.start) begin
               if (sif.nburst != '0) begin
                  w_latch      = 1'b1;
                  w_load       = 1'b1;
                  w_load_val   = w_div_eff - DIV_W'(1);
                  w_state_nxt  = ST_HIGH;
                  w_clkout_nxt = 1'b1;
                  w_q_nxt      = sif.d;
                  w_edge_nxt   = CNT_W'(1);
                  w_busy_nxt   = 1'b1;
               end else begin
                  w_done_nxt   = 1'b1;
                  w_edge_nxt   = '0;
               end
            end
         end
         ST_HIGH: begin
            if (w_tc) begin
               w_load       = 1'b1;
               w_state_nxt  = ST_LOW;
               w_clkout_nxt = 1'b0;
            end
         end
         ST_LOW: begin
            if (w_tc) begin
               // Another edge only while below the target, so edge_cnt saturates
               if (r_edge_cnt < r_nburst) begin
                  w_load       = 1'b1;
                  w_state_nxt  = ST_HIGH;
                  w_clkout_nxt = 1'b1;
                  w_q_nxt      = sif.d;
                  w_edge_nxt   = r_edge_cnt + CNT_W'(1);
               end else begin
                  w_state_nxt  = ST_IDLE;
                  w_busy_nxt   = 1'b0;
                  w_done_nxt   = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Early termination keeps edge_cnt and q as they stand
      if (w_abort && (r_state != ST_IDLE)) begin
         w_state_nxt  = ST_IDLE;
         w_load       = 1'b0;
         w_clkout_nxt = 1'b0;
         w_q_nxt      = r_q;
         w_busy_nxt   = 1'b0;
         w_done_nxt   = 1'b1;
         w_edge_nxt   = r_edge_cnt;
      end
   end

   // Output and burst-parameter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clkout   <= RST_CLKOUT;
         r_q        <= RST_Q;
         r_busy     <= RST_BUSY;
         r_done     <= RST_DONE;
         r_edge_cnt <= CNT_W'(RST_EDGE_CNT);
         r_div      <= DIV_W'(DIV_MIN);
         r_nburst   <= '0;
      end else begin
         r_clkout   <= w_clkout_nxt;
         r_q        <= w_q_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_edge_cnt <= w_edge_nxt;
         if (w_latch) begin
            r_div    <= w_div_eff;
            r_nburst <= sif.nburst;
         end
      end
   end

   assign sif.clkout   = r_clkout;
   assign sif.q        = r_q;
   assign sif.busy     = r_busy;
   assign sif.done     = r_done;
   assign sif.edge_cnt = r_edge_cnt;
endmodule

// File: doc/clkout_sched.md
# clkout_sched

Burst controller for a derived clock output and the flop it drives. On a start request it emits a programmable number of `clkout` pulses of programmable half-period, and captures `d` into `q` on every `clkout` rising edge. It sits between a cosimulation testbench sequencer and the derived-clock register path, replacing a free-running `clkout = clk` copy with a scheduled, countable clock.

## Interface

Parameters:
- `DIV_W`, default 8: width of the half-period field.
- `CNT_W`, default 8: width of the burst count and edge counter.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock. Every register updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request a burst. Sampled only in IDLE.
- `div` input DIV_W: half-period of `clkout`, in `clk` cycles. Latched at start. A value of 0 is treated as 1.
- `nburst` input CNT_W: number of `clkout` rising edges to emit. Latched at start.
- `d` input 1: data to capture.
- `clkout` output 1: registered derived clock.
- `q` output 1: value of `d` captured at each `clkout` rise.
- `busy` output 1: high while a burst is in progress.
- `done` output 1: one-cycle pulse at the end of a burst.
- `edge_cnt` output CNT_W: number of rising edges issued in the current or last burst.

## Operation

- States: IDLE, HIGH, LOW.
- IDLE, `start`=1 and `nburst`≠0:
  - Latch `max(div,1)` and `nburst`.
  - Go to HIGH. On that edge: `clkout`<=1, `q`<=`d`, `edge_cnt`<=1, `busy`<=1.
- IDLE, `start`=1 and `nburst`=0:
  - Pulse `done` next cycle and clear `edge_cnt`.
  - No `clkout` edge; `q` unchanged.
- HIGH: hold for div cycles, then go to LOW (`clkout`<=0).
- LOW: hold for div cycles, then:
  - If `edge_cnt` < `nburst`: go to HIGH, with `clkout`<=1, `q`<=`d`, `edge_cnt`+1.
  - Otherwise: go to IDLE, with `busy`<=0 and `done`<=1.
- `q` changes only on a `clkout` 0→1 transition or on reset.
- `start` while busy is ignored. No queuing.
- A `start` in the cycle `done` is high is accepted, giving back-to-back bursts.
- `edge_cnt` does not wrap; it saturates at `nburst`. It holds its value in IDLE until the next accepted start.
- Reset mid-burst: the next cycle has state IDLE and every output 0. The partial burst is lost and produces no `done`.

## Timing

- Reset values: `clkout`=0, `q`=0, `busy`=0, `done`=0, `edge_cnt`=0.
- Latency: start accepted in cycle 0 gives `clkout`=1 and `busy`=1 in cycle 1.
- `clkout` period is 2·div cycles at 50% duty.
- A burst of n edges occupies cycles 1..2·n·div. `done`=1 with `busy`=0 in cycle 2·n·div+1.
- `q` in cycle k equals `d` sampled in cycle k−1, where k is a `clkout` rise cycle.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration

- Macro: `CLKOUT_SCHED_ABORT_EN`.
- Defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 while busy: the next cycle has `clkout`=0, `busy`=0, `done`=1, state IDLE.
  - `edge_cnt` keeps the edges already issued; `q` keeps its value.
  - `abort` in IDLE has no effect. `abort` and `reset` together: reset wins, so no `done`.
- Undefined: no `abort` port exists, and every burst runs to completion unless reset.

## Structure

- Package `clkout_sched_pkg` holds:
  - the state enum (IDLE, HIGH, LOW);
  - constant `DIV_MIN`=1;
  - the reset-value constants for the outputs.
- Sub-module `clkout_sched_phase_cnt`: loadable down-counter of width DIV_W, with `load`, `load_val`, and a `tc` terminal-count output. It times each HIGH/LOW phase.
- The top level holds the FSM, the latched `nburst`, `edge_cnt`, and the `q` capture flop.

## Test plan

- Reset, then idle 5 cycles → `clkout`=`q`=`busy`=`done`=0 and `edge_cnt`=0 throughout.
- `div`=2, `nburst`=3, `d`=1, start in cycle 0 → `clkout` high in cycles 1–2, 5–6, 9–10; `q`=1 from cycle 1; `done` only in cycle 13; `edge_cnt`=3.
- `div`=0, `nburst`=2 → `clkout` pattern 1,0,1,0 over cycles 1–4; `done` in cycle 5. A further start in cycle 5 restarts with `clkout`=1 in cycle 6.
- `nburst`=0 → `done` in cycle 1, `clkout` stays 0, `q` unchanged.
- `div`=1, `nburst`=4, `d` toggling every cycle starting at 1 → `q` in cycles 1, 3, 5, 7 equals `d` from cycles 0, 2, 4, 6 (all 1).
- Mid-burst events:
  - `start` held high throughout is ignored.
  - `reset` in cycle 4 → all outputs 0 in cycle 5, and no `done`.
  - With `CLKOUT_SCHED_ABORT_EN`: `abort` in cycle 6 of the `div`=2, `nburst`=3 run → `done`=1 and `edge_cnt`=2 in cycle 7.
